// File: rtl/mem_arbiter.sv
// Four-core round-robin arbiter for a single shared byte-wide memory port.
// Each core issues 16-bit writes or 8-bit reads and receives a one-cycle ack.
module mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  req,
    input  logic [3:0]                  wr,
    input  logic [4*ADDR_WIDTH-1:0]     addr,
    input  logic [8*DATA_WIDTH-1:0]     wdata,
    output logic [3:0]                  ack,
    output logic [4*DATA_WIDTH-1:0]     rdata,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [2*DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    output logic                        busy,
    output logic [1:0]                  grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t                  state, state_d;
    logic [1:0]              rr_ptr, rr_ptr_d;
    logic [1:0]              grant_id_d;
    logic [3:0]              ack_d;
    logic                    mem_we_d;
    logic                    busy_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [2*DATA_WIDTH-1:0] mem_wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q [4];
    logic [DATA_WIDTH-1:0]   rdata_d [4];

    logic [ADDR_WIDTH-1:0]   addr_arr  [4];
    logic [2*DATA_WIDTH-1:0] wdata_arr [4];
    logic [3:0]              req_rot;
    logic [1:0]              offset;
    logic [1:0]              winner;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_arr[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = wdata[i*2*DATA_WIDTH +: 2*DATA_WIDTH];
        end
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_rdata
            assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = rdata_q[g];
        end
    endgenerate

    // Rotate requests so bit 0 is the core at rr_ptr; the lowest set bit wins.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_rot[i] = req[rr_ptr + 2'(i)];
        end
        offset = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) offset = 2'(i);
        end
        winner = rr_ptr + offset;
    end

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        grant_id_d  = grant_id;
        ack_d       = 4'b0000;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rdata_d     = rdata_q;

        case (state)
            IDLE: begin
                if (|req) begin
                    grant_id_d  = winner;
                    mem_addr_d  = addr_arr[winner];
                    mem_wdata_d = wdata_arr[winner];
                    mem_we_d    = wr[winner];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // mem_we still holds the latched op type during ISSUE.
                if (mem_we) begin
                    ack_d[grant_id] = 1'b1;
                    rr_ptr_d        = grant_id + 2'd1;
                    state_d         = ACK;
                end else begin
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                rdata_d[grant_id] = mem_rdata;
                ack_d[grant_id]   = 1'b1;
                rr_ptr_d          = grant_id + 2'd1;
                state_d           = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 2'd0;
            grant_id  <= 2'd0;
            ack       <= 4'b0000;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            grant_id  <= grant_id_d;
            ack       <= ack_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule
